// File: rtl/display_pkg.sv
// Shared types and constants for the 8-digit multiplexed hex display scheduler.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int FCNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // Requester that wins the next tie from IDLE.
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] frame_t;

endpackage

// File: rtl/refresh_divider.sv
// Free-running digit-slot divider; tick is high on the last count of each slot.
module refresh_divider #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/display_scheduler.sv
// Two-requester arbiter for a scanned 8-digit hex display; ownership and the
// displayed data only ever change at frame boundaries.
module display_scheduler
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [7:0]  anode,
  output logic [2:0]  seg_sel,
  output logic [3:0]  hex_digit,
  output logic        blank
);

  localparam logic [FCNT_W-1:0] HOLD = FCNT_W'(HOLD_FRAMES);

  logic                  tick;
  logic                  boundary;
  logic [IDX_W-1:0]      idx;
  state_t                state, state_nxt;
  rr_t                   rr, rr_nxt;
  logic [FCNT_W-1:0]     fcnt, fcnt_nxt, frames_done;
  frame_t                frame, frame_nxt;
  logic [NUM_DIGITS-1:0] anode_own;

  refresh_divider #(.REFRESH_DIV(REFRESH_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign boundary = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // Frames completed by the current owner including the one ending now.
  assign frames_done = (fcnt >= HOLD) ? HOLD : fcnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    idx <= '0;
    else if (tick) idx <= idx + 1'b1;
  end

  // State register plus everything that commits with it at a boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr    <= RR_A;
      fcnt  <= '0;
      frame <= '0;
    end else if (boundary) begin
      state <= state_nxt;
      rr    <= rr_nxt;
      fcnt  <= fcnt_nxt;
      frame <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_a && req_b) state_nxt = (rr == RR_A) ? OWN_A : OWN_B;
        else if (req_a)     state_nxt = OWN_A;
        else if (req_b)     state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                          state_nxt = req_b ? OWN_B : IDLE;
        else if (req_b && frames_done >= HOLD) state_nxt = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                          state_nxt = req_a ? OWN_A : IDLE;
        else if (req_a && frames_done >= HOLD) state_nxt = OWN_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and the snapshot for the frame about to start.
  always_comb begin
    rr_nxt    = rr;
    fcnt_nxt  = '0;
    frame_nxt = '0;
    if (state_nxt != state) begin
      if (state_nxt == OWN_A) rr_nxt = RR_B;
      if (state_nxt == OWN_B) rr_nxt = RR_A;
    end else if (state != IDLE) begin
      fcnt_nxt = frames_done;
    end
    if (state_nxt == OWN_A) frame_nxt = frame_t'(data_a);
    if (state_nxt == OWN_B) frame_nxt = frame_t'(data_b);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_anode
    assign anode_own[g] = (idx != IDX_W'(g));
  end

  always_comb begin
    grant_a   = (state == OWN_A);
    grant_b   = (state == OWN_B);
    seg_sel   = idx;
    blank     = 1'b1;
    anode     = 8'hFF;
    hex_digit = 4'h0;
    if (state != IDLE) begin
      blank     = 1'b0;
      anode     = anode_own;
      hex_digit = frame[idx];
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Frame-level scoreboard bench for display_scheduler with REFRESH_DIV=4, HOLD_FRAMES=2.
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        grant_a, grant_b, blank;
  logic [7:0]  anode;
  logic [2:0]  seg_sel;
  logic [3:0]  hex_digit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scheduler #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .anode     (anode),
    .seg_sel   (seg_sel),
    .hex_digit (hex_digit),
    .blank     (blank)
  );

  typedef struct {
    logic [2:0] sel;
    logic [7:0] an;
    logic [3:0] hx;
    logic       bl;
    logic       ga;
    logic       gb;
  } exp_t;

  exp_t        sb[$];
  int          act_d = -1;
  logic        act_ra = 1'b0;
  logic [31:0] act_da = '0;
  int          fno = 0;

  localparam logic [31:0] DA = 32'h89AB_CDEF;
  localparam logic [31:0] DB = 32'h7654_3210;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic ega, input logic egb, input logic [31:0] d);
    logic [7:0] one;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      one   = 8'h01 << i;
      e.sel = 3'(i);
      e.ga  = ega;
      e.gb  = egb;
      e.bl  = !(ega || egb);
      e.an  = e.bl ? 8'hFF : ~one;
      e.hx  = e.bl ? 4'h0 : d[4*i +: 4];
      sb.push_back(e);
    end
  endtask

  task automatic compare(input string ctx);
    exp_t e;
    if (sb.size() == 0) begin
      chk({ctx, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({ctx, " seg_sel"}, 32'(seg_sel), 32'(e.sel));
    chk({ctx, " anode"}, 32'(anode), 32'(e.an));
    chk({ctx, " hex"}, 32'(hex_digit), 32'(e.hx));
    chk({ctx, " blank"}, 32'(blank), 32'(e.bl));
    chk({ctx, " grant_a"}, 32'(grant_a), 32'(e.ga));
    chk({ctx, " grant_b"}, 32'(grant_b), 32'(e.gb));
  endtask

  // Called at the negedge that starts a frame; returns at the next frame start.
  task automatic run_frame(input logic ega, input logic egb, input logic [31:0] d);
    push_frame(ega, egb, d);
    for (int di = 0; di < 8; di++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0 && di == act_d) begin
          req_a  = act_ra;
          data_a = act_da;
          act_d  = -1;
        end
        if (c == 1) compare($sformatf("f%0d d%0d", fno, di));
        if (c == 3) chk($sformatf("f%0d d%0d sel_hold", fno, di), 32'(seg_sel), 32'(di));
        @(negedge clk);
      end
    end
    fno++;
  endtask

  task automatic chk_reset_outputs(input string ctx);
    chk({ctx, " grant_a"}, 32'(grant_a), 32'd0);
    chk({ctx, " grant_b"}, 32'(grant_b), 32'd0);
    chk({ctx, " anode"}, 32'(anode), 32'hFF);
    chk({ctx, " seg_sel"}, 32'(seg_sel), 32'd0);
    chk({ctx, " hex"}, 32'(hex_digit), 32'd0);
    chk({ctx, " blank"}, 32'(blank), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    reset = 1'b1;
    fno   = 0;

    // Idle scanning, then A requests and owns from the next frame.
    run_frame(1'b0, 1'b0, '0);
    run_frame(1'b0, 1'b0, '0);
    req_a  = 1'b1;
    data_a = 32'h1234_ABCD;
    run_frame(1'b0, 1'b0, '0);
    data_a = 32'h0;
    run_frame(1'b1, 1'b0, 32'h1234_ABCD);

    // Mid-frame data change must not leak into the current frame.
    act_d = 3; act_ra = 1'b1; act_da = 32'hFFFF_FFFF;
    run_frame(1'b1, 1'b0, 32'h0);

    // Owner drops its request mid-frame: held to the boundary, then idle.
    act_d = 4; act_ra = 1'b0; act_da = 32'hFFFF_FFFF;
    run_frame(1'b1, 1'b0, 32'hFFFF_FFFF);
    run_frame(1'b0, 1'b0, '0);

    // Fresh reset, then contention: A first, alternating every 2 frames.
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    @(negedge clk);
    reset  = 1'b1;
    fno    = 0;
    req_a  = 1'b1;
    req_b  = 1'b1;
    data_a = DA;
    data_b = DB;
    run_frame(1'b0, 1'b0, '0);
    run_frame(1'b1, 1'b0, DA);
    run_frame(1'b1, 1'b0, DA);
    run_frame(1'b0, 1'b1, DB);
    run_frame(1'b0, 1'b1, DB);
    run_frame(1'b1, 1'b0, DA);
    run_frame(1'b1, 1'b0, DA);

    // Asynchronous reset at digit 5 while B owns the display.
    for (int k = 0; k < 21; k++) @(negedge clk);
    chk("f7 d5 pre_rst seg_sel", 32'(seg_sel), 32'd5);
    chk("f7 d5 pre_rst grant_b", 32'(grant_b), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst2");
    @(negedge clk);
    reset = 1'b1;
    fno   = 0;
    run_frame(1'b0, 1'b0, '0);
    run_frame(1'b1, 1'b0, DA);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
